// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, sequencer state encoding, GF(2^8) helpers.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam int         AES_DW    = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1; also drives the rcon sequence.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host-side block interface: plaintext/key in, ciphertext out, both valid/ready.
interface aes_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int DW = AES_DW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] pt_in;
  logic [DW-1:0] key_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] ct_out;

  modport master (
    output in_valid, pt_in, key_in, out_ready,
    input  in_ready, out_valid, ct_out
  );

  modport slave (
    input  in_valid, pt_in, key_in, out_ready,
    output in_ready, out_valid, ct_out
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: holds state and round key, steps the external
// combinational round datapath and key-step unit once per clock.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int DW = AES_DW
) (
  input  logic          clk,
  input  logic          rst,
  aes_round_ctrl_if.slave host,
  output logic [DW-1:0] dp_state_o,
  output logic [DW-1:0] dp_rkey_o,
  output logic          dp_final_o,
  input  logic [DW-1:0] dp_state_i,
  output logic [DW-1:0] ks_key_o,
  output logic [7:0]    ks_rcon_o,
  input  logic [DW-1:0] ks_key_i,
  output logic          busy
);

  aes_state_e    state_q, state_d;
  logic [DW-1:0] state_reg;
  logic [DW-1:0] key_reg;
  logic [3:0]    rnd_q;
  logic [7:0]    rcon_q;
  logic          last_rnd;

  assign last_rnd = (rnd_q == 4'(NR));

  // Handshake and status flags are pure decodes of the FSM state.
  assign host.in_ready  = (state_q == IDLE);
  assign host.out_valid = (state_q == DONE);
  assign host.ct_out    = state_reg;
  assign busy           = (state_q != IDLE);

  // Round datapath / key-step hookup. The round key used this cycle is the
  // key-step output, so key_reg always trails the datapath by one round.
  assign dp_state_o = state_reg;
  assign dp_rkey_o  = ks_key_i;
  assign dp_final_o = (state_q == ROUND) && last_rnd;
  assign ks_key_o   = key_reg;
  assign ks_rcon_o  = rcon_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept only from IDLE, so a request coincident with the
  // output handshake waits one cycle for in_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (host.in_valid)  state_d = ROUND;
      ROUND:   if (last_rnd)       state_d = DONE;
      DONE:    if (host.out_ready) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State/key/round-counter/rcon registers; inputs are captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      rnd_q     <= '0;
      rcon_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (host.in_valid) begin
          state_reg <= host.pt_in ^ host.key_in;
          key_reg   <= host.key_in;
          rnd_q     <= 4'd1;
          rcon_q    <= RCON_INIT;
        end
        ROUND: begin
          state_reg <= dp_state_i;
          key_reg   <= ks_key_i;
          rcon_q    <= xtime(rcon_q);
          if (!last_rnd) rnd_q <= rnd_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: closes the loop with a behavioural AES round and
// key step, then checks FIPS-197 vectors, rcon/final sequencing, backpressure,
// back-to-back acceptance and mid-block reset.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] dp_state_o, dp_rkey_o, dp_state_i, ks_key_o, ks_key_i;
  logic         dp_final_o, busy;
  logic [7:0]   ks_rcon_o;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sbox [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;

  aes_round_ctrl_if #(.DW(AES_DW)) host ();

  aes_round_ctrl #(.NR(AES_NR), .DW(AES_DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .dp_state_o (dp_state_o),
    .dp_rkey_o  (dp_rkey_o),
    .dp_final_o (dp_final_o),
    .dp_state_i (dp_state_i),
    .ks_key_o   (ks_key_o),
    .ks_rcon_o  (ks_rcon_o),
    .ks_key_i   (ks_key_i),
    .busy       (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} >> (8 - n);
    return t[7:0];
  endfunction

  // S-box from first principles: inverse (x^254) then affine map.
  function automatic logic [7:0] sb_calc(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ rol8(r, 1) ^ rol8(r, 2) ^ rol8(r, 3) ^ rol8(r, 4) ^ 8'h63;
  endfunction

  // Byte i of the block is bits [8i+:8], i = 4*column + row.
  function automatic logic [127:0] tb_round(input logic [127:0] s, input logic [127:0] rk,
                                            input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) t[4*c+k] = b[4*((c+k)%4)+k];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (fin) begin
        r[32*c +: 32] = {a3, a2, a1, a0};
      end else begin
        r[32*c+0  +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        r[32*c+8  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        r[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        r[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return r ^ rk;
  endfunction

  function automatic logic [127:0] tb_kstep(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0]  w3, rw, tmp;
    logic [127:0] n;
    w3  = k[127:96];
    rw  = {w3[7:0], w3[31:8]};
    tmp = {sbox[rw[31:24]], sbox[rw[23:16]], sbox[rw[15:8]], sbox[rw[7:0]] ^ rc};
    n[31:0]   = k[31:0]   ^ tmp;
    n[63:32]  = k[63:32]  ^ n[31:0];
    n[95:64]  = k[95:64]  ^ n[63:32];
    n[127:96] = k[127:96] ^ n[95:64];
    return n;
  endfunction

  // FIPS-197 prints byte 0 first; the block keeps byte 0 in the low bits.
  function automatic logic [127:0] rev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  assign dp_state_i = tb_round(dp_state_o, dp_rkey_o, dp_final_o);
  assign ks_key_i   = tb_kstep(ks_key_o, ks_rcon_o);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid (bounded); cnt = edges waited. Optionally checks
  // rcon and final-round flag for each round while waiting.
  task automatic wait_ov(input string tag, input bit seq_chk, output int cnt);
    cnt = 0;
    while (!host.out_valid && cnt < 40) begin
      if (seq_chk && cnt < 10) begin
        chk($sformatf("%s_rcon%0d", tag, cnt + 1), 128'(ks_rcon_o), 128'(rcon_tab[cnt]));
        chk($sformatf("%s_final%0d", tag, cnt + 1), 128'(dp_final_o), 128'(cnt == 9));
      end
      step();
      cnt++;
    end
  endtask

  // One block with out_ready high: accept, latency, ciphertext, return to IDLE.
  task automatic run_vec(input string tag, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] ct, input bit seq_chk);
    int cnt;
    host.pt_in     = pt;
    host.key_in    = key;
    host.in_valid  = 1'b1;
    host.out_ready = 1'b1;
    step();
    host.in_valid = 1'b0;
    host.pt_in    = ~pt;
    host.key_in   = ~key;
    chk({tag, "_busy"}, 128'({busy, host.in_ready}), 128'(2'b10));
    wait_ov(tag, seq_chk, cnt);
    chk({tag, "_lat"}, 128'(cnt), 128'(10));
    chk({tag, "_ct"}, host.ct_out, ct);
    step();
    chk({tag, "_idle"}, 128'({host.out_valid, host.in_ready, busy}), 128'(3'b010));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int  cnt;
    bit  seen;
    for (int i = 0; i < 256; i++) sbox[i] = sb_calc(8'(i));
    rst            = 1'b1;
    host.in_valid  = 1'b0;
    host.out_ready = 1'b0;
    host.pt_in     = '0;
    host.key_in    = '0;
    step();
    step();

    // Reset values.
    chk("rst_flags", 128'({host.out_valid, host.in_ready, busy}), 128'(3'b010));
    chk("rst_ct", host.ct_out, 128'h0);
    chk("rst_key", ks_key_o, 128'h0);
    rst = 1'b0;
    step();

    // FIPS-197 C.1 and B (with per-round rcon / final checks).
    run_vec("c1", rev(C1_PT), rev(C1_KEY), rev(C1_CT), 1'b0);
    run_vec("fb", rev(B_PT), rev(B_KEY), rev(B_CT), 1'b1);

    // Backpressure: hold the result 20 cycles while in_valid pulses arrive.
    host.pt_in     = rev(B_PT);
    host.key_in    = rev(B_KEY);
    host.in_valid  = 1'b1;
    host.out_ready = 1'b0;
    step();
    host.in_valid = 1'b0;
    wait_ov("bp", 1'b0, cnt);
    chk("bp_lat", 128'(cnt), 128'(10));
    for (int i = 0; i < 20; i++) begin
      host.in_valid = i[0];
      host.pt_in    = {4{$urandom}};
      host.key_in   = {4{$urandom}};
      step();
      chk($sformatf("bp_ct%0d", i), host.ct_out, rev(B_CT));
      chk($sformatf("bp_fl%0d", i), 128'({host.out_valid, host.in_ready, busy}), 128'(3'b101));
    end
    host.in_valid  = 1'b0;
    host.out_ready = 1'b1;
    step();
    chk("bp_rel", 128'({host.out_valid, host.in_ready, busy}), 128'(3'b010));

    // Back-to-back with in_valid held high.
    host.pt_in    = rev(C1_PT);
    host.key_in   = rev(C1_KEY);
    host.in_valid = 1'b1;
    step();
    host.pt_in  = rev(B_PT);
    host.key_in = rev(B_KEY);
    wait_ov("bb1", 1'b0, cnt);
    chk("bb1_lat", 128'(cnt), 128'(10));
    chk("bb1_ct", host.ct_out, rev(C1_CT));
    chk("bb1_rdy", 128'(host.in_ready), 128'(0));
    step();
    chk("bb_gap", 128'({host.out_valid, host.in_ready, busy}), 128'(3'b010));
    step();
    host.in_valid = 1'b0;
    chk("bb2_acc", 128'({host.in_ready, busy}), 128'(2'b01));
    wait_ov("bb2", 1'b0, cnt);
    chk("bb2_lat", 128'(cnt), 128'(10));
    chk("bb2_ct", host.ct_out, rev(B_CT));
    step();

    // Reset during round 5 discards the block.
    host.pt_in    = rev(C1_PT);
    host.key_in   = rev(C1_KEY);
    host.in_valid = 1'b1;
    step();
    host.in_valid = 1'b0;
    repeat (4) step();
    chk("mr_rcon5", 128'(ks_rcon_o), 128'(8'h10));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_flags", 128'({host.out_valid, host.in_ready, busy}), 128'(3'b010));
    chk("mr_ct", host.ct_out, 128'h0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (host.out_valid) seen = 1'b1;
    end
    chk("mr_noov", 128'(seen), 128'(0));
    run_vec("c1b", rev(C1_PT), rev(C1_KEY), rev(C1_CT), 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
